// File: rtl/morra_pkg.sv
// Shared codes and state encoding for the Morra Cinese match sequencer.
// Move and result codes are plain 2-bit constants so they map straight onto engine pins.
package morra_pkg;

    localparam logic [1:0] MOVE_NONE = 2'b00;
    localparam logic [1:0] SASSO     = 2'b01;
    localparam logic [1:0] CARTA     = 2'b10;
    localparam logic [1:0] FORBICE   = 2'b11;

    localparam logic [1:0] RES_NULL  = 2'b00;
    localparam logic [1:0] RES_P1    = 2'b01;
    localparam logic [1:0] RES_P2    = 2'b10;
    localparam logic [1:0] RES_DRAW  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_G_START,
        ST_COLLECT,
        ST_ISSUE,
        ST_WAIT,
        ST_G_END,
        ST_DONE
    } state_t;

endpackage

// File: rtl/morra_move_capture.sv
// One-entry valid/ready holding register for a single player's move.
// o_move_nxt exposes the value that will be held after this edge, so the top can issue without a bubble.
module morra_move_capture (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_clr,
    input  logic       i_valid,
    input  logic [1:0] i_move,
    output logic       o_ready,
    output logic       o_take,
    output logic       o_full,
    output logic [1:0] o_move_nxt
);

    logic       r_full;
    logic [1:0] r_move;

    assign o_ready    = i_en && !r_full;
    assign o_take     = i_valid && o_ready;
    assign o_full     = r_full;
    assign o_move_nxt = r_full ? r_move : i_move;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_move <= 2'b00;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end else if (o_take) begin
            r_full <= 1'b1;
            r_move <= i_move;
        end
    end

endmodule

// File: rtl/morra_match_sequencer.sv
// Best-of-N match controller: restarts the engine per game, feeds one move pair
// per round, samples ROUND/GAME after ENG_LAT cycles and keeps the match score.
module morra_match_sequencer
    import morra_pkg::*;
#(
    parameter int GAMES_TO_WIN = 2,
    parameter int MAX_GAMES    = 5,
    parameter int ENG_LAT      = 2,
    localparam int SW = $clog2(GAMES_TO_WIN + 1),
    localparam int GW = $clog2(MAX_GAMES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          match_start,
    input  logic [3:0]    cfg_rounds,
    input  logic          p1_valid,
    input  logic [1:0]    p1_move,
    output logic          p1_ready,
    input  logic          p2_valid,
    input  logic [1:0]    p2_move,
    output logic          p2_ready,
    output logic [1:0]    eng_p1,
    output logic [1:0]    eng_p2,
    output logic          eng_start,
    input  logic [1:0]    eng_round,
    input  logic [1:0]    eng_game,
    output logic          round_valid,
    output logic [1:0]    round_result,
    output logic          game_valid,
    output logic [1:0]    game_result,
    output logic [SW-1:0] score_p1,
    output logic [SW-1:0] score_p2,
    output logic [GW-1:0] games_played,
    output logic          busy,
    output logic          match_done,
    output logic [1:0]    match_winner
);

    localparam logic [SW-1:0] GTW      = SW'(GAMES_TO_WIN);
    localparam logic [GW-1:0] MAXG     = GW'(MAX_GAMES);
    localparam logic [2:0]    LAT_LAST = 3'(ENG_LAT - 1);

    state_t        r_state;
    logic [2:0]    r_cnt;
    logic [1:0]    r_eng_p1, r_eng_p2;
    logic          r_eng_start;
    logic          r_round_valid, r_game_valid;
    logic [1:0]    r_round_result, r_game_result, r_game, r_winner;
    logic [SW-1:0] r_score1, r_score2;
    logic [GW-1:0] r_gp;

    logic          w_take1, w_take2, w_full1, w_full2;
    logic [1:0]    w_mv1, w_mv2;
    logic          w_both;
    logic [SW-1:0] w_s1n, w_s2n;
    logic [GW-1:0] w_gpn;

    morra_move_capture u_cap_p1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (r_state == ST_COLLECT),
        .i_clr      (r_state == ST_ISSUE),
        .i_valid    (p1_valid),
        .i_move     (p1_move),
        .o_ready    (p1_ready),
        .o_take     (w_take1),
        .o_full     (w_full1),
        .o_move_nxt (w_mv1)
    );

    morra_move_capture u_cap_p2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (r_state == ST_COLLECT),
        .i_clr      (r_state == ST_ISSUE),
        .i_valid    (p2_valid),
        .i_move     (p2_move),
        .o_ready    (p2_ready),
        .o_take     (w_take2),
        .o_full     (w_full2),
        .o_move_nxt (w_mv2)
    );

    // Both moves held after this edge, counting a capture happening right now.
    assign w_both = (w_full1 || w_take1) && (w_full2 || w_take2);

    assign w_s1n = r_score1 + SW'(r_game == RES_P1);
    assign w_s2n = r_score2 + SW'(r_game == RES_P2);
    assign w_gpn = r_gp + GW'(1);

    assign eng_p1       = r_eng_p1;
    assign eng_p2       = r_eng_p2;
    assign eng_start    = r_eng_start;
    assign round_valid  = r_round_valid;
    assign round_result = r_round_result;
    assign game_valid   = r_game_valid;
    assign game_result  = r_game_result;
    assign score_p1     = r_score1;
    assign score_p2     = r_score2;
    assign games_played = r_gp;
    assign match_winner = r_winner;
    assign busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign match_done   = (r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 3'd0;
            r_eng_p1       <= MOVE_NONE;
            r_eng_p2       <= MOVE_NONE;
            r_eng_start    <= 1'b0;
            r_round_valid  <= 1'b0;
            r_round_result <= RES_NULL;
            r_game_valid   <= 1'b0;
            r_game_result  <= RES_NULL;
            r_game         <= RES_NULL;
            r_winner       <= RES_NULL;
            r_score1       <= '0;
            r_score2       <= '0;
            r_gp           <= '0;
        end else begin
            r_eng_start   <= 1'b0;
            r_eng_p1      <= MOVE_NONE;
            r_eng_p2      <= MOVE_NONE;
            r_round_valid <= 1'b0;
            r_game_valid  <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (match_start) begin
                        r_state               <= ST_G_START;
                        r_eng_start           <= 1'b1;
                        {r_eng_p1, r_eng_p2}  <= cfg_rounds;
                        r_score1              <= '0;
                        r_score2              <= '0;
                        r_gp                  <= '0;
                        r_winner              <= RES_NULL;
                    end
                end
                ST_G_START: r_state <= ST_COLLECT;
                ST_COLLECT: begin
                    if (w_both) begin
                        r_state  <= ST_ISSUE;
                        r_eng_p1 <= w_mv1;
                        r_eng_p2 <= w_mv2;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= 3'd0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == LAT_LAST) begin
                        r_round_valid  <= 1'b1;
                        r_round_result <= eng_round;
                        r_game         <= eng_game;
                        r_state        <= (eng_game == RES_NULL) ? ST_COLLECT : ST_G_END;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_G_END: begin
                    r_game_valid  <= 1'b1;
                    r_game_result <= r_game;
                    r_score1      <= w_s1n;
                    r_score2      <= w_s2n;
                    r_gp          <= w_gpn;
                    if (w_s1n == GTW) begin
                        r_winner <= RES_P1;
                        r_state  <= ST_DONE;
                    end else if (w_s2n == GTW) begin
                        r_winner <= RES_P2;
                        r_state  <= ST_DONE;
                    end else if (w_gpn == MAXG) begin
                        r_winner <= (w_s1n > w_s2n) ? RES_P1 :
                                    (w_s2n > w_s1n) ? RES_P2 : RES_DRAW;
                        r_state  <= ST_DONE;
                    end else begin
                        r_state              <= ST_G_START;
                        r_eng_start          <= 1'b1;
                        {r_eng_p1, r_eng_p2} <= cfg_rounds;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morra_match_sequencer.sv
// Self-checking bench: a behavioural engine stand-in plus a score model,
// driven by a vector table, hand-written corner sequences and random rounds.
module tb_morra_match_sequencer;

    localparam int GTW = 2;
    localparam int MAXG = 5;
    localparam int LAT = 2;
    localparam int SW = $clog2(GTW + 1);
    localparam int GW = $clog2(MAXG + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          match_start = 1'b0;
    logic [3:0]    cfg_rounds = 4'd0;
    logic          p1_valid = 1'b0, p2_valid = 1'b0;
    logic [1:0]    p1_move = 2'd0, p2_move = 2'd0;
    logic          p1_ready, p2_ready;
    logic [1:0]    eng_p1, eng_p2, eng_round, eng_game;
    logic          eng_start;
    logic          round_valid, game_valid, busy, match_done;
    logic [1:0]    round_result, game_result, match_winner;
    logic [SW-1:0] score_p1, score_p2;
    logic [GW-1:0] games_played;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    morra_match_sequencer #(.GAMES_TO_WIN(GTW), .MAX_GAMES(MAXG), .ENG_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .match_start(match_start), .cfg_rounds(cfg_rounds),
        .p1_valid(p1_valid), .p1_move(p1_move), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_move(p2_move), .p2_ready(p2_ready),
        .eng_p1(eng_p1), .eng_p2(eng_p2), .eng_start(eng_start),
        .eng_round(eng_round), .eng_game(eng_game),
        .round_valid(round_valid), .round_result(round_result),
        .game_valid(game_valid), .game_result(game_result),
        .score_p1(score_p1), .score_p2(score_p2), .games_played(games_played),
        .busy(busy), .match_done(match_done), .match_winner(match_winner)
    );

    wire [31:0] all_out = {8'd0, eng_p1, eng_p2, eng_start, p1_ready, p2_ready, round_valid,
                           round_result, game_valid, game_result, score_p1, score_p2,
                           games_played, busy, match_done, match_winner};

    function automatic logic [1:0] rref(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b00 || b == 2'b00) return 2'b00;
        if (a == b) return 2'b11;
        if ((a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) || (a == 2'b11 && b == 2'b10))
            return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [1:0] gres(input int a, input int b);
        return (a > b) ? 2'b01 : (a < b) ? 2'b10 : 2'b11;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Engine stand-in: a game is game_len non-null plays, won by the majority.
    int         game_len = 1;
    int         e_pl = 0, e_w1 = 0, e_w2 = 0;
    logic [1:0] e_r [LAT];
    logic [1:0] e_g [LAT];
    logic [1:0] e_rnd, e_gm;
    logic       e_end;

    always_comb begin
        e_rnd = eng_start ? 2'b00 : rref(eng_p1, eng_p2);
        e_end = (e_rnd != 2'b00) && (e_pl + 1 == game_len);
        e_gm  = e_end ? gres(e_w1 + ((e_rnd == 2'b01) ? 1 : 0), e_w2 + ((e_rnd == 2'b10) ? 1 : 0))
                      : 2'b00;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                e_r[i] <= 2'b00;
                e_g[i] <= 2'b00;
            end
        end else begin
            e_r[0] <= e_rnd;
            e_g[0] <= e_gm;
            for (int i = 1; i < LAT; i++) begin
                e_r[i] <= e_r[i-1];
                e_g[i] <= e_g[i-1];
            end
        end
        if (eng_start || e_end) begin
            e_pl <= 0; e_w1 <= 0; e_w2 <= 0;
        end else if (e_rnd != 2'b00) begin
            e_pl <= e_pl + 1;
            if (e_rnd == 2'b01) e_w1 <= e_w1 + 1;
            if (e_rnd == 2'b10) e_w2 <= e_w2 + 1;
        end
    end

    assign eng_round = e_r[LAT-1];
    assign eng_game  = e_g[LAT-1];

    // Match reference model
    int         m_s1, m_s2, m_gp, g_pl, g_w1, g_w2;
    logic [1:0] m_win;
    bit         m_done;

    task automatic model_clear();
        m_s1 = 0; m_s2 = 0; m_gp = 0; g_pl = 0; g_w1 = 0; g_w2 = 0;
        m_win = 2'b00; m_done = 1'b0;
    endtask

    task automatic start_match(input logic [3:0] cfg);
        @(negedge clk);
        cfg_rounds = cfg;
        match_start = 1'b1;
        @(negedge clk);
        match_start = 1'b0;
        chk("gstart_eng_start", int'(eng_start), 1);
        chk("gstart_eng_p1", int'(eng_p1), int'(cfg[3:2]));
        chk("gstart_eng_p2", int'(eng_p2), int'(cfg[1:0]));
        chk("gstart_cleared", int'({score_p1, score_p2, games_played, match_winner, match_done}), 0);
        chk("gstart_busy", int'(busy), 1);
        @(negedge clk);
        chk("collect_ready", int'({p1_ready, p2_ready}), 3);
        chk("collect_eng_start", int'(eng_start), 0);
        model_clear();
    endtask

    task automatic step(input logic [1:0] m1, input logic [1:0] m2,
                        input int d1, input int d2, input logic [1:0] er);
        bit c1 = 0, c2 = 0, h1 = 0, h2 = 0, gend = 0;
        int t = 0, lat = 0;
        logic [1:0] g = 2'b00;
        while (!(c1 && c2) && t < 40) begin
            @(negedge clk);
            if (c1 && !h1) begin chk("p1_ready_drop", int'(p1_ready), 0); h1 = 1; end
            if (c2 && !h2) begin chk("p2_ready_drop", int'(p2_ready), 0); h2 = 1; end
            p1_valid = !c1 && (t >= d1);
            p2_valid = !c2 && (t >= d2);
            p1_move = m1;
            p2_move = m2;
            if (p1_valid && p1_ready) c1 = 1;
            if (p2_valid && p2_ready) c2 = 1;
            t++;
        end
        if (!(c1 && c2)) begin
            chk("capture_timeout", 0, 1);
            p1_valid = 1'b0; p2_valid = 1'b0;
            return;
        end
        @(negedge clk);
        p1_valid = 1'b0; p2_valid = 1'b0;
        chk("issue_p1", int'(eng_p1), int'(m1));
        chk("issue_p2", int'(eng_p2), int'(m2));
        chk("issue_ready", int'({p1_ready, p2_ready}), 0);
        do begin
            @(negedge clk);
            lat++;
        end while (!round_valid && lat < 20);
        chk("round_latency", lat, LAT + 1);
        chk("round_result", int'(round_result), int'(er));
        if (er != 2'b00) begin
            g_pl++;
            if (er == 2'b01) g_w1++;
            if (er == 2'b10) g_w2++;
            if (g_pl == game_len) begin
                gend = 1; g = gres(g_w1, g_w2);
                g_pl = 0; g_w1 = 0; g_w2 = 0;
            end
        end
        @(negedge clk);
        chk("round_pulse", int'(round_valid), 0);
        chk("game_valid", int'(game_valid), int'(gend));
        if (gend) begin
            if (g == 2'b01) m_s1++;
            if (g == 2'b10) m_s2++;
            m_gp++;
            if (m_s1 == GTW) begin m_done = 1; m_win = 2'b01; end
            else if (m_s2 == GTW) begin m_done = 1; m_win = 2'b10; end
            else if (m_gp == MAXG) begin m_done = 1; m_win = gres(m_s1, m_s2); end
            chk("game_result", int'(game_result), int'(g));
            chk("score_p1", int'(score_p1), m_s1);
            chk("score_p2", int'(score_p2), m_s2);
            chk("games_played", int'(games_played), m_gp);
            chk("match_done", int'(match_done), int'(m_done));
            chk("match_winner", int'(match_winner), int'(m_win));
            chk("busy", int'(busy), int'(!m_done));
        end
    endtask

    typedef struct {
        logic [1:0] m1;
        logic [1:0] m2;
        int         d1;
        int         d2;
        logic [1:0] er;
    } vec_t;

    vec_t vt [11];

    initial begin
        // Match A: P1 takes two single-round games. Match B: null, then draw/P1/P2/draw/draw.
        // Match C: P2, P1, P2.
        vt[0]  = '{2'd1, 2'd3, 0, 3, 2'b01};
        vt[1]  = '{2'd2, 2'd1, 0, 0, 2'b01};
        vt[2]  = '{2'd0, 2'd2, 1, 0, 2'b00};
        vt[3]  = '{2'd1, 2'd1, 0, 1, 2'b11};
        vt[4]  = '{2'd1, 2'd3, 2, 0, 2'b01};
        vt[5]  = '{2'd3, 2'd1, 0, 0, 2'b10};
        vt[6]  = '{2'd2, 2'd2, 1, 1, 2'b11};
        vt[7]  = '{2'd3, 2'd3, 0, 2, 2'b11};
        vt[8]  = '{2'd2, 2'd3, 0, 0, 2'b10};
        vt[9]  = '{2'd3, 2'd2, 0, 0, 2'b01};
        vt[10] = '{2'd1, 2'd2, 0, 0, 2'b10};

        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs", int'(all_out), 0);

        game_len = 1;
        start_match(4'b0000);

        match_start = 1'b1;
        @(negedge clk);
        match_start = 1'b0;
        chk("start_in_collect_ignored", int'(eng_start), 0);
        chk("collect_still_busy", int'({busy, p1_ready}), 3);

        for (int i = 0; i < 11; i++) begin
            if (m_done) start_match(4'($urandom_range(0, 15)));
            step(vt[i].m1, vt[i].m2, vt[i].d1, vt[i].d2, vt[i].er);
            if (i == 7) begin
                chk("draw_match_played", int'(games_played), 5);
                chk("draw_match_scores", int'({score_p1, score_p2}), 5);
                chk("draw_match_winner", int'(match_winner), 3);
            end
        end
        chk("matchC_winner", int'(match_winner), 2);

        // Reset while waiting on the engine
        start_match(4'b1001);
        @(negedge clk);
        p1_move = 2'b01; p2_move = 2'b10;
        p1_valid = 1'b1; p2_valid = 1'b1;
        @(negedge clk);
        p1_valid = 1'b0; p2_valid = 1'b0;
        @(negedge clk);
        chk("wait_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_mid_wait", int'(all_out), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", int'(all_out), 0);
        model_clear();
        m_done = 1'b1;

        for (int r = 0; r < 60; r++) begin
            logic [1:0] a, b;
            if (m_done) begin
                game_len = $urandom_range(1, 3);
                start_match(4'($urandom_range(0, 15)));
            end
            a = 2'($urandom_range(0, 3));
            b = 2'($urandom_range(0, 3));
            step(a, b, $urandom_range(0, 3), $urandom_range(0, 3), rref(a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
